// File: rtl/iic_pkg.sv
// Shared types for the I2C target: FSM state encoding and bit-slot constants.
package iic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    WR_NACK,
    RD_LOAD,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } iic_state_e;

  // Bit-counter value that marks the ninth (acknowledge) slot of a byte.
  localparam logic [3:0] ACK_BIT = 4'd8;

endpackage

// File: rtl/iic_target_if.sv
// Open-drain pad bundle for SCL/SDA. slave = the target core, master = pad/bus side.
interface iic_target_if;
  logic scl_i;
  logic scl_o;
  logic scl_t;
  logic sda_i;
  logic sda_o;
  logic sda_t;

  modport master (output scl_i, sda_i, input scl_o, scl_t, sda_o, sda_t);
  modport slave  (input scl_i, sda_i, output scl_o, scl_t, sda_o, sda_t);
endinterface

// File: rtl/iic_line_filter.sv
// Two-flop synchronizer, FILT_LEN-sample glitch filter and edge pulses for one bus line.
module iic_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered level only moves after FILT_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = filt_q;
  assign rise_o  = filt_q & ~prev_q;
  assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/iic_target.sv
// I2C target core: 7-bit address match, write bytes to RX FIFO, read bytes from FWFT TX FIFO
// with SCL stretching while the TX FIFO is empty.
module iic_target
  import iic_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int SDA_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        own_addr,
  output logic              rx_wr,
  output logic [7:0]        rx_data,
  input  logic              rx_full,
  output logic              tx_rd,
  input  logic [7:0]        tx_data,
  input  logic              tx_empty,
  output logic              busy,
  output logic              rw,
  output logic              addr_hit,
  output logic              stop_det,
  output logic              rx_ovf,
  iic_target_if.slave       bus,
  output iic_state_e        dbg_state
);

  localparam int HW = (SDA_HOLD > 1) ? $clog2(SDA_HOLD) : 1;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .pad_i(bus.scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .pad_i(bus.sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  logic          hold_pend_q, hold_pend_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_done;

  // hold_done fires SDA_HOLD cycles after each filtered SCL fall; sda_t moves only then.
  assign hold_done = hold_pend_q && (hold_cnt_q == '0);

  always_comb begin
    hold_pend_d = hold_pend_q;
    hold_cnt_d  = hold_cnt_q;
    if (scl_fall) begin
      hold_pend_d = 1'b1;
      hold_cnt_d  = HW'(SDA_HOLD - 1);
    end else if (hold_done) begin
      hold_pend_d = 1'b0;
    end else if (hold_pend_q) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  iic_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte;
  logic       sda_t_q, sda_t_d;
  logic       scl_t_q, scl_t_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_wr_q, rx_wr_d;
  logic       tx_rd_q, tx_rd_d;
  logic       addr_hit_q, addr_hit_d;
  logic       stop_det_q, stop_det_d;
  logic       rx_ovf_q, rx_ovf_d;

  assign rx_byte = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_t_d    = sda_t_q;
    scl_t_d    = 1'b1;
    busy_d     = busy_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_wr_d    = 1'b0;
    tx_rd_d    = 1'b0;
    addr_hit_d = 1'b0;
    stop_det_d = 1'b0;
    rx_ovf_d   = 1'b0;

    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
    end else if (stop_cond) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: sda_t_d = 1'b1;

        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              if (rx_byte[7:1] == own_addr) begin
                addr_hit_d = 1'b1;
                rw_d       = rx_byte[0];
                busy_d     = 1'b1;
                bit_cnt_d  = ACK_BIT;
                state_d    = ADDR_ACK;
              end else begin
                bit_cnt_d = '0;
                state_d   = WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // First hold after the 8th fall drives ACK, the next one releases it.
        ADDR_ACK, WR_ACK: begin
          if (hold_done) begin
            if (sda_t_q) begin
              sda_t_d = 1'b0;
            end else begin
              sda_t_d   = 1'b1;
              bit_cnt_d = '0;
              state_d   = (state_q == WR_ACK || !rw_q) ? WR_BYTE : RD_LOAD;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = ACK_BIT;
              if (!rx_full) begin
                rx_data_d = rx_byte;
                rx_wr_d   = 1'b1;
                state_d   = WR_ACK;
              end else begin
                rx_ovf_d = 1'b1;
                state_d  = WR_NACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        WR_NACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            state_d   = WAIT_STOP;
          end
        end

        // SCL is already low here; holding scl_t low stretches the clock until data exists.
        RD_LOAD: begin
          if (tx_empty) begin
            scl_t_d = 1'b0;
          end else begin
            shift_d   = tx_data;
            tx_rd_d   = 1'b1;
            sda_t_d   = tx_data[7];
            bit_cnt_d = '0;
            state_d   = RD_BYTE;
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (hold_done) begin
            if (bit_cnt_q == ACK_BIT) begin
              sda_t_d = 1'b1;
              state_d = RD_ACK;
            end else begin
              sda_t_d = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end

        // bit_cnt returns to 0 on an initiator ACK; the reload waits for the following fall+hold.
        RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (sda_lvl) state_d = WAIT_STOP;
          end else if (hold_done && bit_cnt_q == '0) begin
            state_d = RD_LOAD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_t_q     <= 1'b1;
      scl_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_wr_q     <= 1'b0;
      tx_rd_q     <= 1'b0;
      addr_hit_q  <= 1'b0;
      stop_det_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
      hold_pend_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_t_q     <= sda_t_d;
      scl_t_q     <= scl_t_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      rx_data_q   <= rx_data_d;
      rx_wr_q     <= rx_wr_d;
      tx_rd_q     <= tx_rd_d;
      addr_hit_q  <= addr_hit_d;
      stop_det_q  <= stop_det_d;
      rx_ovf_q    <= rx_ovf_d;
      hold_pend_q <= hold_pend_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.scl_o = 1'b0;
  assign bus.sda_o = 1'b0;
  assign bus.scl_t = scl_t_q;
  assign bus.sda_t = sda_t_q;
  assign rx_wr     = rx_wr_q;
  assign rx_data   = rx_data_q;
  assign tx_rd     = tx_rd_q;
  assign busy      = busy_q;
  assign rw        = rw_q;
  assign addr_hit  = addr_hit_q;
  assign stop_det  = stop_det_q;
  assign rx_ovf    = rx_ovf_q;
  assign dbg_state = state_q;

endmodule
